// File: rtl/mipsfpga_lcd_pkg.sv
// rtl/mipsfpga_lcd_pkg.sv - shared types and defaults for the LCD SPI block
package mipsfpga_lcd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    GAP      = 2'd3
  } lcd_state_t;

  // Queue entry is {rs, data[7:0]}
  localparam int ENTRY_W        = 9;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_FIFO_DEPTH = 8;

endpackage

// File: rtl/mipsfpga_lcd_fifo.sv
// rtl/mipsfpga_lcd_fifo.sv - command FIFO with registered count and show-ahead read
module mipsfpga_lcd_fifo
  import mipsfpga_lcd_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] pop_data,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               push_ok;
  logic               pop_ok;

  // Flags come from the registered count, so a push while full is dropped even if a pop frees a slot this cycle
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mipsfpga_lcd_spi.sv
// rtl/mipsfpga_lcd_spi.sv - queued SPI mode-0 serializer driving an LCD with a register-select line
module mipsfpga_lcd_spi
  import mipsfpga_lcd_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       SI_ClkIn,
  input  logic       SI_Reset,
  input  logic       wr_en,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic       lcd_rs,
  output logic       lcd_sdo,
  output logic       lcd_sck
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  lcd_state_t         state_q, state_d;
  logic [7:0]         div_q, div_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         byte_q, byte_d;
  logic               rs_d, sdo_d, sck_d;
  logic               pop;
  logic [ENTRY_W-1:0] fifo_dout;
  logic               div_done;
  logic [2:0]         bit_next;

  mipsfpga_lcd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (SI_ClkIn),
    .rst       (SI_Reset),
    .push      (wr_en),
    .push_data ({wr_rs, wr_data}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (full),
    .empty     (empty)
  );

  assign div_done = (div_q == DIV_LAST);
  assign bit_next = bit_q - 3'd1;
  assign busy     = (state_q != IDLE) | ~empty;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    rs_d    = lcd_rs;
    sdo_d   = lcd_sdo;
    sck_d   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SHIFT_LO;
          rs_d    = fifo_dout[8];
          byte_d  = fifo_dout[7:0];
          sdo_d   = fifo_dout[7];
          bit_d   = 3'd7;
          div_d   = '0;
        end
      end
      SHIFT_LO: begin
        if (div_done) begin
          div_d   = '0;
          sck_d   = 1'b1;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        sck_d = 1'b1;
        // Data only moves together with the falling sck edge
        if (div_done) begin
          div_d = '0;
          sck_d = 1'b0;
          if (bit_q != 3'd0) begin
            bit_d   = bit_next;
            sdo_d   = byte_q[bit_next];
            state_d = SHIFT_LO;
          end else begin
            state_d = GAP;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GAP: begin
        if (div_done) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
    if (SI_Reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      lcd_rs  <= 1'b0;
      lcd_sdo <= 1'b0;
      lcd_sck <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      lcd_rs  <= rs_d;
      lcd_sdo <= sdo_d;
      lcd_sck <= sck_d;
    end
  end

  always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
    if (SI_Reset)            ovf <= 1'b0;
    else if (wr_en && full)  ovf <= 1'b1;
    else if (ovf_clr)        ovf <= 1'b0;
  end

endmodule

// File: tb/tb_mipsfpga_lcd_spi.sv
// tb/tb_mipsfpga_lcd_spi.sv - self-checking bench for mipsfpga_lcd_spi
module tb_mipsfpga_lcd_spi;

  localparam int CD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, wr_rs = 1'b0, ovf_clr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, busy, ovf, lcd_rs, lcd_sdo, lcd_sck;
  logic       wr_en_1 = 1'b0, wr_rs_1 = 1'b0, ovf_clr_1 = 1'b0;
  logic [7:0] wr_data_1 = 8'h00;
  logic       full_1, empty_1, busy_1, ovf_1, lcd_rs_1, lcd_sdo_1, lcd_sck_1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mipsfpga_lcd_spi #(.CLK_DIV(CD), .FIFO_DEPTH(8)) u_dut (
    .SI_ClkIn(clk), .SI_Reset(rst), .wr_en(wr_en), .wr_rs(wr_rs), .wr_data(wr_data),
    .full(full), .empty(empty), .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr),
    .lcd_rs(lcd_rs), .lcd_sdo(lcd_sdo), .lcd_sck(lcd_sck)
  );

  mipsfpga_lcd_spi #(.CLK_DIV(1), .FIFO_DEPTH(8)) u_dut1 (
    .SI_ClkIn(clk), .SI_Reset(rst), .wr_en(wr_en_1), .wr_rs(wr_rs_1), .wr_data(wr_data_1),
    .full(full_1), .empty(empty_1), .busy(busy_1), .ovf(ovf_1), .ovf_clr(ovf_clr_1),
    .lcd_rs(lcd_rs_1), .lcd_sdo(lcd_sdo_1), .lcd_sck(lcd_sck_1)
  );

  // Frame monitor: gathers sdo on every sck rise, MSB first, 8 bits per frame
  int         rise_total = 0;
  int         bit_n = 0;
  logic       prev_sck = 1'b0;
  logic [7:0] sh = 8'h00;
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];

  always @(negedge clk) begin
    if (rst) begin
      prev_sck = 1'b0;
      bit_n    = 0;
    end else begin
      if (lcd_sck && !prev_sck) begin
        rise_total++;
        sh = {sh[6:0], lcd_sdo};
        bit_n++;
        if (bit_n == 8) begin
          rx_q.push_back({lcd_rs, sh});
          bit_n = 0;
        end
      end
      prev_sck = lcd_sck;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic rs, input logic [7:0] d);
    wr_en = 1'b1; wr_rs = rs; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (busy && cycles < budget) begin
      step();
      cycles++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_idle_timeout: busy=%0b after %0d cycles, required 0", busy, cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    tests_run++;
    if ({empty, full, busy, ovf, lcd_sck, lcd_sdo, lcd_rs} !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_state: {empty,full,busy,ovf,sck,sdo,rs}=%b required 1000000",
               {empty, full, busy, ovf, lcd_sck, lcd_sdo, lcd_rs});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    int cyc;
    int base;
    rx_q.delete();
    base = rise_total;
    push(1'b1, 8'hA5);
    wait_idle(200, cyc);
    tests_run++;
    if (cyc != 1 + 17*CD) begin
      tests_failed++;
      $display("FAIL single_frame_len: busy low after %0d cycles, required %0d", cyc, 1 + 17*CD);
    end
    tests_run++;
    if (rise_total - base != 8) begin
      tests_failed++;
      $display("FAIL single_rises: %0d sck rises, required 8", rise_total - base);
    end
    tests_run++;
    if (rx_q.size() != 1 || rx_q[0] !== 9'h1A5) begin
      tests_failed++;
      $display("FAIL single_data: %0d frames, first=%h, required 1 frame 1a5", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 9'h000);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    logic [8:0] e;
    rx_q.delete();
    exp_q.delete();
    e = 9'($urandom);
    push(e[8], e[7:0]);
    exp_q.push_back(e);
    step();
    step();
    for (int i = 0; i < 9; i++) begin
      e = 9'($urandom);
      push(e[8], e[7:0]);
      if (i < 8) exp_q.push_back(e);
    end
    tests_run++;
    if ({full, ovf, empty} !== 3'b110) begin
      tests_failed++;
      $display("FAIL ovf_set: {full,ovf,empty}=%b required 110", {full, ovf, empty});
    end
    wr_en = 1'b1; ovf_clr = 1'b1; wr_data = 8'hEE;
    step();
    wr_en = 1'b0; ovf_clr = 1'b0;
    tests_run++;
    if (ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_clr_vs_drop: ovf=%b required 1", ovf);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clr: ovf=%b required 0", ovf);
    end
    wait_idle(600, cyc);
    tests_run++;
    if (rx_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL ovf_frame_count: %0d frames, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (rx_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL ovf_order[%0d]: got %h required %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic sck_log[100];
    logic rs_log[100];
    int   falls, low_after, rs_low, rs_tog, cyc;
    bit   seen_high, done;
    rx_q.delete();
    push(1'b0, 8'h3C);
    push(1'b1, 8'hC3);
    for (int i = 0; i < 100; i++) begin
      step();
      sck_log[i] = lcd_sck;
      rs_log[i]  = lcd_rs;
    end
    wait_idle(100, cyc);
    falls = 0; low_after = 0; rs_low = 0; rs_tog = 0; seen_high = 0; done = 0;
    for (int i = 1; i < 100; i++) begin
      if (seen_high && rs_log[i] != rs_log[i-1]) rs_tog++;
      if (sck_log[i]) seen_high = 1;
      if (!sck_log[i] && sck_log[i-1]) falls++;
      if (falls == 8 && sck_log[i]) done = 1;
      if (falls == 8 && !sck_log[i] && !done) begin
        low_after++;
        if (!rs_log[i]) rs_low++;
      end
    end
    tests_run++;
    if (rs_low != CD + 1) begin
      tests_failed++;
      $display("FAIL b2b_gap: %0d sck-low cycles before frame 2 start, required %0d", rs_low, CD + 1);
    end
    tests_run++;
    if (low_after != 2*CD + 1) begin
      tests_failed++;
      $display("FAIL b2b_low_run: %0d low cycles between frames, required %0d", low_after, 2*CD + 1);
    end
    tests_run++;
    if (rs_tog != 1) begin
      tests_failed++;
      $display("FAIL b2b_rs_toggle: %0d rs changes, required 1", rs_tog);
    end
    tests_run++;
    if (rx_q.size() != 2 || rx_q[0] !== 9'h03C || rx_q[1] !== 9'h1C3) begin
      tests_failed++;
      $display("FAIL b2b_data: %0d frames, required 03c then 1c3", rx_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    int base, cyc;
    logic [7:0] d;
    rx_q.delete();
    push(1'b1, 8'($urandom));
    push(1'b0, 8'($urandom));
    base = rise_total;
    cyc = 0;
    while ((rise_total - base) < 4 && cyc < 200) begin
      step();
      cyc++;
    end
    tests_run++;
    if (rise_total - base < 4) begin
      tests_failed++;
      $display("FAIL midreset_reach: %0d rises seen, required 4", rise_total - base);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({empty, full, busy, ovf, lcd_sck, lcd_sdo, lcd_rs} !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL midreset_outputs: {empty,full,busy,ovf,sck,sdo,rs}=%b required 1000000",
               {empty, full, busy, ovf, lcd_sck, lcd_sdo, lcd_rs});
    end
    step();
    step();
    rst = 1'b0;
    base = rise_total;
    repeat (60) step();
    tests_run++;
    if (rise_total != base || busy !== 1'b0 || rx_q.size() != 0) begin
      tests_failed++;
      $display("FAIL midreset_quiet: rises=%0d busy=%b frames=%0d, required 0 0 0",
               rise_total - base, busy, rx_q.size());
    end
    d = 8'($urandom);
    push(1'b1, d);
    wait_idle(200, cyc);
    tests_run++;
    if (rx_q.size() != 1 || rx_q[0] !== {1'b1, d}) begin
      tests_failed++;
      $display("FAIL midreset_clean_frame: %0d frames, required one frame %h", rx_q.size(), {1'b1, d});
    end
  endtask

  task automatic test_push_pop();
    int cyc;
    logic [8:0] a, b;
    rx_q.delete();
    a = 9'($urandom);
    b = 9'($urandom);
    push(a[8], a[7:0]);
    push(b[8], b[7:0]);
    tests_run++;
    if ({empty, full, busy} !== 3'b001) begin
      tests_failed++;
      $display("FAIL pushpop_flags: {empty,full,busy}=%b required 001", {empty, full, busy});
    end
    wait_idle(200, cyc);
    tests_run++;
    if (rx_q.size() != 2 || rx_q[0] !== a || rx_q[1] !== b || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL pushpop_order: %0d frames empty=%b, required %h then %h, empty 1",
               rx_q.size(), empty, a, b);
    end
  endtask

  task automatic test_random();
    int cyc, n;
    logic [8:0] e;
    for (int r = 0; r < 6; r++) begin
      rx_q.delete();
      exp_q.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        e = 9'($urandom);
        push(e[8], e[7:0]);
        exp_q.push_back(e);
        repeat ($urandom_range(0, 3)) step();
      end
      wait_idle(400, cyc);
      tests_run++;
      if (rx_q.size() != exp_q.size()) begin
        tests_failed++;
        $display("FAIL random_count[%0d]: %0d frames, required %0d", r, rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
        tests_run++;
        if (rx_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL random_data[%0d][%0d]: got %h required %h", r, i, rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_clkdiv1();
    logic [7:0] d, got;
    logic       prev;
    int         last, n, cyc;
    d = 8'($urandom);
    wr_en_1 = 1'b1; wr_rs_1 = 1'b1; wr_data_1 = d;
    step();
    wr_en_1 = 1'b0;
    prev = 1'b0; last = -1; n = 0; cyc = 0; got = 8'h00;
    while (busy_1 && cyc < 100) begin
      step();
      cyc++;
      if (lcd_sck_1 && !prev) begin
        got = {got[6:0], lcd_sdo_1};
        if (last >= 0) begin
          tests_run++;
          if (cyc - last != 2) begin
            tests_failed++;
            $display("FAIL div1_period: rise spacing %0d, required 2", cyc - last);
          end
        end
        last = cyc;
        n++;
      end
      prev = lcd_sck_1;
    end
    tests_run++;
    if (cyc != 18) begin
      tests_failed++;
      $display("FAIL div1_frame_len: %0d cycles, required 18", cyc);
    end
    tests_run++;
    if (n != 8 || got !== d || lcd_rs_1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL div1_data: rises=%0d data=%h rs=%b, required 8 %h 1", n, got, lcd_rs_1, d);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_back_to_back();
    test_push_pop();
    test_reset_midframe();
    test_random();
    test_clkdiv1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
